// File: rtl/irda_pkg.sv
// Shared definitions for the IrDA MIR receive path.
//   - FSM state encodings for irda_mir_rx_ctrl
//   - status-word bit positions and a helper that packs a status word
package irda_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESTART = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_RECV    = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;
  localparam logic [2:0] ST_STATUS  = 3'd5;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned LEN_W        = 16;
  localparam int unsigned STAT_W       = 20;
  localparam int unsigned STAT_LEN_LSB = 0;
  localparam int unsigned STAT_LEN_MSB = 15;
  localparam int unsigned STAT_CRC     = 16;
  localparam int unsigned STAT_OVR     = 17;
  localparam int unsigned STAT_BRK     = 18;
  localparam int unsigned STAT_TMO     = 19;

  // Pack one per-frame status word.
  function automatic logic [STAT_W-1:0] stat_word(input logic [LEN_W-1:0] len,
                                                  input logic crc,
                                                  input logic ovr,
                                                  input logic brk,
                                                  input logic tmo);
    logic [STAT_W-1:0] w;
    w = '0;
    w[STAT_LEN_MSB:STAT_LEN_LSB] = len;
    w[STAT_CRC] = crc;
    w[STAT_OVR] = ovr;
    w[STAT_BRK] = brk;
    w[STAT_TMO] = tmo;
    return w;
  endfunction

endpackage

// File: rtl/irda_sync_fifo.sv
// Generic synchronous show-ahead FIFO (head entry always on dat_o).
// Ports: clk, wb_rst_i (async, active-high), push_i/dat_i write side,
//        pop_i read side, dat_o head word, empty_o, count_o occupancy,
//        ovf_c pulses when a push is dropped because the FIFO is full.
// A push while full is accepted if a pop happens in the same cycle;
// a pop while empty is ignored.
module irda_sync_fifo #(
  parameter int unsigned W  = 20,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          wb_rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  dat_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_c
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic          do_push, do_pop;

  // A full FIFO is never empty, so pop_i alone frees the slot.
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | pop_i);
  assign ovf_c   = push_i & full_q & ~pop_i;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/irda_mir_rx_ctrl.sv
// Frame-level controller for the MIR receive path.
// Sequences irda_mir_rx (restart while disabled), forwards received words to
// the RX data FIFO, detects data overrun, and queues one status word per
// frame in an internal status FIFO. Drives frame / overrun interrupts.
// Ports: clk, wb_rst_i (async, active-high); rx_en_i; receiver side
//   (mir_rxbit_enable, rx_word_i/rx_word_valid_i, mir_sto_detected,
//   mir_crc_error, mir_ifdlr_o, mir_rx_error, mir_rx_restart); data FIFO side
//   (dfifo_full_i, dfifo_push_o, dfifo_dat_o); status FIFO side (stat_pop_i,
//   stat_dat_o, stat_empty_o, stat_count_o); irq_frame_o, irq_ovr_o, irq_clr_i.
// Optional: define IRDA_MIR_RX_TIMEOUT_EN to abort a frame after TIMEOUT_BITS
//   bit strobes without a received word (status bit 19).
module irda_mir_rx_ctrl
  import irda_pkg::*;
#(
  parameter int unsigned STAT_AW      = 2,
  parameter int unsigned TIMEOUT_BITS = 1024
) (
  input  logic                clk,
  input  logic                wb_rst_i,
  input  logic                rx_en_i,
  input  logic                mir_rxbit_enable,
  input  logic [WORD_W-1:0]   rx_word_i,
  input  logic                rx_word_valid_i,
  input  logic                mir_sto_detected,
  input  logic                mir_crc_error,
  input  logic [LEN_W-1:0]    mir_ifdlr_o,
  input  logic                mir_rx_error,
  output logic                mir_rx_restart,
  input  logic                dfifo_full_i,
  output logic                dfifo_push_o,
  output logic [WORD_W-1:0]   dfifo_dat_o,
  input  logic                stat_pop_i,
  output logic [STAT_W-1:0]   stat_dat_o,
  output logic                stat_empty_o,
  output logic [STAT_AW:0]    stat_count_o,
  output logic                irq_frame_o,
  output logic                irq_ovr_o,
  input  logic                irq_clr_i
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               ovr_q, ovr_d;
  logic               sto_q;
  logic               restart_q;
  logic               dpush_q, dpush_d;
  logic [WORD_W-1:0]  ddat_q, ddat_d;
  logic               irq_ovr_q, irq_ovr_d;
  logic               stat_push_c;
  logic [STAT_W-1:0]  stat_word_c;
  logic               ovr_evt_c;
  logic               stat_ovf_c;
  logic               tmo_hit_c;
  logic               sto_rise_c, sto_fall_c;
  logic               in_frame_c;

  assign sto_rise_c = mir_sto_detected & ~sto_q;
  assign sto_fall_c = ~mir_sto_detected & sto_q;
  assign in_frame_c = (state_q == ST_RECV) | (state_q == ST_DROP);

`ifdef IRDA_MIR_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_BITS + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit_c = in_frame_c & (tmo_cnt_q == TMO_W'(TIMEOUT_BITS));

  // Idle-bit counter: runs only inside a frame, restarts on every word.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!in_frame_c || rx_word_valid_i) tmo_cnt_d = '0;
    else if (mir_rxbit_enable && !tmo_hit_c) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = mir_rxbit_enable ^ (TIMEOUT_BITS == 0);
  assign tmo_hit_c  = 1'b0;
`endif

  // Next-state, forwarding and status-push decode.
  always_comb begin
    state_d     = state_q;
    ovr_d       = ovr_q;
    dpush_d     = 1'b0;
    ddat_d      = ddat_q;
    stat_push_c = 1'b0;
    stat_word_c = stat_word(mir_ifdlr_o, 1'b0, ovr_q, 1'b0, 1'b0);
    ovr_evt_c   = 1'b0;

    if (!rx_en_i) begin
      state_d = ST_IDLE;
      ovr_d   = 1'b0;
    end else if (mir_rx_error && (state_q == ST_ARMED || in_frame_c ||
                                  state_q == ST_STATUS)) begin
      // Break: frames in progress report it; an armed receiver just restarts.
      if (state_q != ST_ARMED) begin
        stat_push_c = 1'b1;
        stat_word_c = stat_word(mir_ifdlr_o, 1'b0, ovr_q, 1'b1, 1'b0);
      end
      state_d = ST_RESTART;
    end else if (tmo_hit_c) begin
      stat_push_c = 1'b1;
      stat_word_c = stat_word(mir_ifdlr_o, 1'b0, ovr_q, 1'b0, 1'b1);
      state_d     = ST_RESTART;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RESTART;
        ST_RESTART: begin
          ovr_d   = 1'b0;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          ovr_d = 1'b0;
          if (rx_word_valid_i) begin
            if (dfifo_full_i) begin
              ovr_d     = 1'b1;
              ovr_evt_c = 1'b1;
              state_d   = ST_DROP;
            end else begin
              dpush_d = 1'b1;
              ddat_d  = rx_word_i;
              state_d = ST_RECV;
            end
          end else if (sto_rise_c) begin
            state_d = ST_STATUS;
          end
        end
        ST_RECV: begin
          if (rx_word_valid_i && !dfifo_full_i) begin
            dpush_d = 1'b1;
            ddat_d  = rx_word_i;
          end else if (rx_word_valid_i) begin
            ovr_d     = 1'b1;
            ovr_evt_c = 1'b1;
            state_d   = ST_DROP;
          end
          if (mir_sto_detected) state_d = ST_STATUS;
        end
        ST_DROP: begin
          if (mir_sto_detected) state_d = ST_STATUS;
        end
        ST_STATUS: begin
          // Length and CRC are only valid as STO drops.
          if (sto_fall_c) begin
            stat_push_c = 1'b1;
            stat_word_c = stat_word(mir_ifdlr_o, mir_crc_error, ovr_q, 1'b0, 1'b0);
            state_d     = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Overrun interrupt: a set in the same cycle as a clear wins.
  always_comb begin
    irq_ovr_d = irq_ovr_q;
    if (irq_clr_i) irq_ovr_d = 1'b0;
    if (ovr_evt_c || stat_ovf_c) irq_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ovr_q     <= 1'b0;
      sto_q     <= 1'b0;
      restart_q <= 1'b1;
      dpush_q   <= 1'b0;
      ddat_q    <= '0;
      irq_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovr_q     <= ovr_d;
      sto_q     <= mir_sto_detected;
      restart_q <= (state_d == ST_IDLE) | (state_d == ST_RESTART);
      dpush_q   <= dpush_d;
      ddat_q    <= ddat_d;
      irq_ovr_q <= irq_ovr_d;
    end
  end

  irda_sync_fifo #(
    .W  (STAT_W),
    .AW (STAT_AW)
  ) u_stat_fifo (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .push_i   (stat_push_c),
    .dat_i    (stat_word_c),
    .pop_i    (stat_pop_i),
    .dat_o    (stat_dat_o),
    .empty_o  (stat_empty_o),
    .count_o  (stat_count_o),
    .ovf_c    (stat_ovf_c)
  );

  assign mir_rx_restart = restart_q;
  assign dfifo_push_o   = dpush_q;
  assign dfifo_dat_o    = ddat_q;
  assign irq_frame_o    = ~stat_empty_o;
  assign irq_ovr_o      = irq_ovr_q;

endmodule

// File: tb/tb_irda_mir_rx_ctrl.sv
// Directed self-checking bench for irda_mir_rx_ctrl (STAT_AW=2, TIMEOUT_BITS=8).
module tb_irda_mir_rx_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        rx_en_i;
  logic        mir_rxbit_enable;
  logic [31:0] rx_word_i;
  logic        rx_word_valid_i;
  logic        mir_sto_detected;
  logic        mir_crc_error;
  logic [15:0] mir_ifdlr_o;
  logic        mir_rx_error;
  logic        mir_rx_restart;
  logic        dfifo_full_i;
  logic        dfifo_push_o;
  logic [31:0] dfifo_dat_o;
  logic        stat_pop_i;
  logic [19:0] stat_dat_o;
  logic        stat_empty_o;
  logic [2:0]  stat_count_o;
  logic        irq_frame_o;
  logic        irq_ovr_o;
  logic        irq_clr_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] pushed [$];

  always #5 clk = ~clk;

  irda_mir_rx_ctrl #(.STAT_AW(2), .TIMEOUT_BITS(8)) dut (
    .clk              (clk),
    .wb_rst_i         (wb_rst_i),
    .rx_en_i          (rx_en_i),
    .mir_rxbit_enable (mir_rxbit_enable),
    .rx_word_i        (rx_word_i),
    .rx_word_valid_i  (rx_word_valid_i),
    .mir_sto_detected (mir_sto_detected),
    .mir_crc_error    (mir_crc_error),
    .mir_ifdlr_o      (mir_ifdlr_o),
    .mir_rx_error     (mir_rx_error),
    .mir_rx_restart   (mir_rx_restart),
    .dfifo_full_i     (dfifo_full_i),
    .dfifo_push_o     (dfifo_push_o),
    .dfifo_dat_o      (dfifo_dat_o),
    .stat_pop_i       (stat_pop_i),
    .stat_dat_o       (stat_dat_o),
    .stat_empty_o     (stat_empty_o),
    .stat_count_o     (stat_count_o),
    .irq_frame_o      (irq_frame_o),
    .irq_ovr_o        (irq_ovr_o),
    .irq_clr_i        (irq_clr_i)
  );

  // Record every word written to the data FIFO.
  always @(posedge clk) if (!wb_rst_i && dfifo_push_o) pushed.push_back(dfifo_dat_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    rx_word_i       = w;
    rx_word_valid_i = 1'b1;
    cyc();
    rx_word_valid_i = 1'b0;
  endtask

  // STO high for two cycles, then length/CRC presented as STO falls.
  task automatic end_frame(input logic [15:0] len, input logic crc, input logic pop);
    mir_sto_detected = 1'b1;
    cyc();
    cyc();
    mir_sto_detected = 1'b0;
    mir_ifdlr_o      = len;
    mir_crc_error    = crc;
    stat_pop_i       = pop;
    cyc();
    mir_crc_error    = 1'b0;
    stat_pop_i       = 1'b0;
  endtask

  task automatic pop_stat();
    stat_pop_i = 1'b1;
    cyc();
    stat_pop_i = 1'b0;
  endtask

  task automatic pulse_clr();
    irq_clr_i = 1'b1;
    cyc();
    irq_clr_i = 1'b0;
  endtask

  logic [31:0] exp_drain [4];

  initial begin
    wb_rst_i = 1'b1;
    rx_en_i = 1'b0; mir_rxbit_enable = 1'b0; rx_word_i = '0; rx_word_valid_i = 1'b0;
    mir_sto_detected = 1'b0; mir_crc_error = 1'b0; mir_ifdlr_o = '0; mir_rx_error = 1'b0;
    dfifo_full_i = 1'b0; stat_pop_i = 1'b0; irq_clr_i = 1'b0;
    cyc(); cyc();

    // Reset values
    check("rst_restart", 32'(mir_rx_restart), 32'd1);
    check("rst_dpush",   32'(dfifo_push_o),   32'd0);
    check("rst_ddat",    dfifo_dat_o,         32'd0);
    check("rst_empty",   32'(stat_empty_o),   32'd1);
    check("rst_count",   32'(stat_count_o),   32'd0);
    check("rst_sdat",    32'(stat_dat_o),     32'd0);
    check("rst_irqf",    32'(irq_frame_o),    32'd0);
    check("rst_irqo",    32'(irq_ovr_o),      32'd0);
    wb_rst_i = 1'b0;
    cyc();
    check("idle_restart", 32'(mir_rx_restart), 32'd1);

    // Enable: one RESTART cycle, then ARMED
    rx_en_i = 1'b1;
    cyc();
    check("restart_hi", 32'(mir_rx_restart), 32'd1);
    cyc();
    check("armed_lo", 32'(mir_rx_restart), 32'd0);

    // Normal 3-word frame
    send_word(32'h11111111);
    check("push_pulse", 32'(dfifo_push_o), 32'd1);
    check("push_dat",   dfifo_dat_o, 32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    end_frame(16'd12, 1'b0, 1'b0);
    check("f1_npush", 32'(pushed.size()), 32'd3);
    check("f1_w2",    pushed[2], 32'h33333333);
    check("f1_push_idle", 32'(dfifo_push_o), 32'd0);
    check("f1_stat",  32'(stat_dat_o), 32'h0000C);
    check("f1_irqf",  32'(irq_frame_o), 32'd1);
    check("f1_count", 32'(stat_count_o), 32'd1);
    pop_stat();
    check("f1_pop_empty", 32'(stat_empty_o), 32'd1);
    check("f1_pop_irqf",  32'(irq_frame_o), 32'd0);

    // Frame shorter than one word: STO straight out of ARMED
    end_frame(16'd2, 1'b0, 1'b0);
    check("short_stat", 32'(stat_dat_o), 32'h00002);
    check("short_npush", 32'(pushed.size()), 32'd3);
    pop_stat();

    // Overrun on 2nd word, CRC bad, length 16
    send_word(32'h44444444);
    dfifo_full_i = 1'b1;
    send_word(32'h55555555);
    dfifo_full_i = 1'b0;
    check("ovr_irq_set", 32'(irq_ovr_o), 32'd1);
    send_word(32'h66666666);
    send_word(32'h77777777);
    end_frame(16'd16, 1'b1, 1'b0);
    check("ovr_npush", 32'(pushed.size()), 32'd4);
    check("ovr_w",     pushed[3], 32'h44444444);
    check("ovr_stat",  32'(stat_dat_o), 32'h30010);
    check("ovr_sticky", 32'(irq_ovr_o), 32'd1);
    pulse_clr();
    check("ovr_clr", 32'(irq_ovr_o), 32'd0);
    pop_stat();

    // Break after one word, length 4
    send_word(32'h88888888);
    mir_ifdlr_o  = 16'd4;
    mir_rx_error = 1'b1;
    cyc();
    mir_rx_error = 1'b0;
    check("brk_restart", 32'(mir_rx_restart), 32'd1);
    check("brk_stat",    32'(stat_dat_o), 32'h40004);
    cyc();
    check("brk_restart_lo", 32'(mir_rx_restart), 32'd0);
    send_word(32'h99999999);
    end_frame(16'd4, 1'b0, 1'b0);
    check("brk_next_cnt", 32'(stat_count_o), 32'd2);
    check("brk_head", 32'(stat_dat_o), 32'h40004);
    pop_stat();
    check("brk_next_stat", 32'(stat_dat_o), 32'h00004);
    pop_stat();
    check("brk_npush", 32'(pushed.size()), 32'd6);

    // Status FIFO fill: 4 kept, 5th dropped
    for (int k = 1; k <= 5; k++) begin
      send_word(32'hA0000000 + 32'(k));
      end_frame(16'(16 + k), 1'b0, 1'b0);
      if (k == 4) begin
        check("fill4_cnt", 32'(stat_count_o), 32'd4);
        check("fill4_irqo", 32'(irq_ovr_o), 32'd0);
      end
    end
    check("fill5_cnt",  32'(stat_count_o), 32'd4);
    check("fill5_irqo", 32'(irq_ovr_o), 32'd1);
    check("fill5_head", 32'(stat_dat_o), 32'h00011);
    pulse_clr();
    // 6th frame ends with a concurrent pop
    send_word(32'hA0000006);
    end_frame(16'h16, 1'b0, 1'b1);
    check("pp_cnt",  32'(stat_count_o), 32'd4);
    check("pp_irqo", 32'(irq_ovr_o), 32'd0);
    exp_drain[0] = 32'h00012; exp_drain[1] = 32'h00013;
    exp_drain[2] = 32'h00014; exp_drain[3] = 32'h00016;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 32'(stat_dat_o), exp_drain[i]);
      pop_stat();
    end
    check("drain_empty", 32'(stat_empty_o), 32'd1);
    // Pop on empty is ignored
    pop_stat();
    check("pop_empty_cnt", 32'(stat_count_o), 32'd0);
    check("fill_npush", 32'(pushed.size()), 32'd12);

    // Disable mid-frame: IDLE, no status, words ignored
    send_word(32'hBBBBBBBB);
    rx_en_i = 1'b0;
    cyc();
    check("dis_restart", 32'(mir_rx_restart), 32'd1);
    send_word(32'hCCCCCCCC);
    end_frame(16'd8, 1'b0, 1'b0);
    check("dis_empty", 32'(stat_empty_o), 32'd1);
    check("dis_npush", 32'(pushed.size()), 32'd13);
    check("dis_restart2", 32'(mir_rx_restart), 32'd1);

`ifdef IRDA_MIR_RX_TIMEOUT_EN
    // Timeout: 1 word then 8 idle bit strobes
    rx_en_i = 1'b1;
    cyc(); cyc();
    send_word(32'hDDDDDDDD);
    mir_ifdlr_o = 16'd4;
    for (int i = 0; i < 8; i++) begin
      mir_rxbit_enable = 1'b1;
      cyc();
    end
    mir_rxbit_enable = 1'b0;
    cyc();
    check("tmo_stat",    32'(stat_dat_o), 32'h80004);
    check("tmo_restart", 32'(mir_rx_restart), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irda_mir_rx_ctrl.md
# irda_mir_rx_ctrl

Frame-level controller for the MIR receive path. It sits between the MIR receiver (`irda_mir_rx`) and the Wishbone register/FIFO layer, and sequences the receiver: it holds the receiver in restart while disabled and forwards received 32-bit words into the RX data FIFO. It detects data-FIFO overrun and drops the rest of the frame, and it builds one status word per frame. Status words go into a small internal status FIFO read by software, and the block drives the frame and overrun interrupts.

## Interface
Parameters:
- `STAT_AW`, default 2: status FIFO address width; depth is 2^STAT_AW entries.
- `TIMEOUT_BITS`, default 1024: bit-enable count with no pushed word that aborts a frame. Used only with the timeout macro.

Ports:
- `clk` in 1: system clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `rx_en_i` in 1: software MIR receive enable.
- `mir_rxbit_enable` in 1: MIR bit strobe. Used by the timeout counter.
- `rx_word_i` in 32: receiver word (`rxfifo_dat_i`).
- `rx_word_valid_i` in 1: receiver push strobe (`rxfifo_add`).
- `mir_sto_detected` in 1: receiver is in its STO state.
- `mir_crc_error` in 1: receiver CRC result. Valid in the cycle `mir_sto_detected` falls.
- `mir_ifdlr_o` in 16: receiver frame byte count.
- `mir_rx_error` in 1: break detected.
- `mir_rx_restart` out 1: receiver restart.
- `dfifo_full_i` in 1: RX data FIFO full.
- `dfifo_push_o` out 1: data FIFO write strobe.
- `dfifo_dat_o` out 32: data FIFO write data.
- `stat_pop_i` in 1: status FIFO read strobe.
- `stat_dat_o` out 20: head status word.
- `stat_empty_o` out 1: status FIFO empty.
- `stat_count_o` out STAT_AW+1: number of status entries.
- `irq_frame_o` out 1: status FIFO non-empty.
- `irq_ovr_o` out 1: sticky overrun or status-lost flag.
- `irq_clr_i` in 1: clears `irq_ovr_o`.

## Operation
Status word layout:
- [15:0] frame byte length (`mir_ifdlr_o`).
- [16] CRC error.
- [17] data overrun.
- [18] break abort.
- [19] timeout abort.

State machine:
- IDLE: `mir_rx_restart`=1. Leaves for RESTART when `rx_en_i`=1.
- RESTART: `mir_rx_restart`=1 for exactly one cycle, then → ARMED.
- ARMED: `mir_rx_restart`=0.
  - `rx_word_valid_i` → RECV, and the word is forwarded.
  - Rising edge of `mir_sto_detected` → STATUS. This covers a frame shorter than one word.
- RECV: each `rx_word_valid_i` with `dfifo_full_i`=0 is forwarded.
  - With `dfifo_full_i`=1: set overrun bit, set `irq_ovr_o`, word not forwarded → DROP.
  - `mir_sto_detected`=1 → STATUS.
- DROP: words discarded. `mir_sto_detected` → STATUS, with overrun bit kept.
- STATUS: wait for the falling edge of `mir_sto_detected`. In that cycle, capture `mir_ifdlr_o` and `mir_crc_error`, push the status word, → ARMED.

Abort and disable:
- `mir_rx_error` in RECV/DROP/STATUS: push status with the break bit and current length → RESTART.
- `mir_rx_error` in ARMED: no status → RESTART.
- `rx_en_i`=0 in any state: → IDLE next cycle. No status is pushed and the partial frame is discarded.
- Priority, highest first: `rx_en_i`=0, `mir_rx_error`, timeout, normal transitions.

Status FIFO rules:
- A push when full, without a pop in the same cycle, is dropped and sets `irq_ovr_o`.
- Simultaneous push and pop is always accepted.
- A pop when empty is ignored.

Interrupt clear: `irq_clr_i` clears `irq_ovr_o`. A set in the same cycle wins.

## Timing
- Reset values:
  - state IDLE, so `mir_rx_restart`=1.
  - `dfifo_push_o`=0, `dfifo_dat_o`=0.
  - status FIFO empty, so `stat_empty_o`=1, `stat_count_o`=0, `stat_dat_o`=0.
  - `irq_frame_o`=0, `irq_ovr_o`=0.
- `dfifo_push_o`/`dfifo_dat_o` are registered: one cycle after `rx_word_valid_i`, with a one-cycle pulse per word.
- A status word is visible on `stat_dat_o` (when the FIFO was empty) and `irq_frame_o` rises one cycle after the `mir_sto_detected` falling-edge cycle.
- `stat_dat_o` is show-ahead: it updates one cycle after `stat_pop_i`.
- RESTART → ARMED takes one cycle. The minimum `rx_en_i` rise to first acceptable word is 3 cycles.

## Configuration
- `IRDA_MIR_RX_TIMEOUT_EN` defined: a counter in RECV/DROP increments on `mir_rxbit_enable` and clears on each `rx_word_valid_i`. When it reaches `TIMEOUT_BITS`, status is pushed with the timeout bit → RESTART.
- Undefined: no counter, and bit [19] always reads 0.

## Structure
- Shared package `irda_pkg` holds:
  - state encoding constants;
  - status-word bit-index constants `STAT_LEN_*`, `STAT_CRC`, `STAT_OVR`, `STAT_BRK`, `STAT_TMO`.
- One sub-module: `irda_sync_fifo`, a generic synchronous show-ahead FIFO parameterised by width/address width and used as the status FIFO.

## Test plan
- Enable, then 3 words 0x11111111/0x22222222/0x33333333, STO with crc_error=0, length 12 → 3 data pushes, status 0x0000C, `irq_frame_o`=1.
- `dfifo_full_i`=1 on the 2nd word of a 4-word frame, CRC bad, length 16 → 1 push, status 0x30010, `irq_ovr_o`=1 until `irq_clr_i`.
- `mir_rx_error` after 1 word, length 4 → status 0x40004, `mir_rx_restart` pulses 1 cycle, next frame received normally.
- 5 frames with STAT_AW=2 and no pops → 4 entries kept, 5th dropped, `irq_ovr_o`=1; then a pop concurrent with a 6th frame end keeps count 4.
- With `IRDA_MIR_RX_TIMEOUT_EN`, TIMEOUT_BITS=8: 1 word, then 8 bit-enables idle → status bit19=1, length 4. `rx_en_i`=0 mid-frame → IDLE, no status, `mir_rx_restart`=1.
